// File: rtl/hilo_unit.sv
// HI/LO sequencer: launches the divider or multiplier, waits for its completion
// pulse (bounded by TIMEOUT), and owns the architectural HI/LO registers.
module hilo_unit #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        opStart,
    input  logic [1:0]  opCode,
    input  logic [31:0] rsData,
    input  logic [31:0] rtData,
    output logic        divIn,
    output logic [31:0] divDividendo,
    output logic [31:0] divDivisor,
    input  logic        divOut,
    input  logic [31:0] divHi,
    input  logic [31:0] divLo,
    output logic        mulIn,
    output logic [31:0] mulA,
    output logic [31:0] mulB,
    input  logic        mulOut,
    input  logic [31:0] mulHi,
    input  logic [31:0] mulLo,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        busy,
    output logic        done,
    output logic        divZeroExc,
    output logic        timeoutErr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unit_done;

    // Only the unit that was launched may complete the operation.
    assign unit_done = (op_q == OP_DIV) ? divOut : mulOut;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (opStart) begin
                    op_d = opCode;
                    a_d  = rsData;
                    b_d  = rtData;
                    dz_d = 1'b0;
                    to_d = 1'b0;
                    case (opCode)
                        OP_MTHI: begin
                            hi_d    = rsData;
                            state_d = S_FINISH;
                        end
                        OP_MTLO: begin
                            lo_d    = rsData;
                            state_d = S_FINISH;
                        end
                        OP_DIV: begin
                            if (rtData == 32'd0) begin
                                dz_d    = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                state_d = S_LAUNCH;
                            end
                        end
                        default: state_d = S_LAUNCH;
                    endcase
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion is checked first so it beats a coincident timeout.
                if (unit_done) begin
                    hi_d    = (op_q == OP_DIV) ? divHi : mulHi;
                    lo_d    = (op_q == OP_DIV) ? divLo : mulLo;
                    state_d = S_FINISH;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign divIn        = (state_q == S_LAUNCH) && (op_q == OP_DIV);
    assign mulIn        = (state_q == S_LAUNCH) && (op_q == OP_MULT);
    assign divDividendo = a_q;
    assign divDivisor   = b_q;
    assign mulA         = a_q;
    assign mulB         = b_q;
    assign HiOut        = hi_q;
    assign LoOut        = lo_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign divZeroExc   = dz_q;
    assign timeoutErr   = to_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: random operations against a behavioural HI/LO
// model, with divider/multiplier stubs and a scoreboard popped on every done pulse.
module tb_hilo_unit;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        opStart = 1'b0;
    logic [1:0]  opCode = 2'b00;
    logic [31:0] rsData = '0;
    logic [31:0] rtData = '0;
    logic        divIn;
    logic [31:0] divDividendo, divDivisor;
    logic        divOut = 1'b0;
    logic [31:0] divHi = '0, divLo = '0;
    logic        mulIn;
    logic [31:0] mulA, mulB;
    logic        mulOut = 1'b0;
    logic [31:0] mulHi = '0, mulLo = '0;
    logic [31:0] HiOut, LoOut;
    logic        busy, done, divZeroExc, timeoutErr;

    hilo_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .opStart(opStart), .opCode(opCode),
        .rsData(rsData), .rtData(rtData),
        .divIn(divIn), .divDividendo(divDividendo), .divDivisor(divDivisor),
        .divOut(divOut), .divHi(divHi), .divLo(divLo),
        .mulIn(mulIn), .mulA(mulA), .mulB(mulB),
        .mulOut(mulOut), .mulHi(mulHi), .mulLo(mulLo),
        .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .done(done),
        .divZeroExc(divZeroExc), .timeoutErr(timeoutErr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        to;
        int          doneCyc;
        int          divStrobes;
        int          mulStrobes;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    // Architectural model of HI/LO
    logic [31:0] mHi = '0, mLo = '0;

    // Stub configuration for the operation being issued
    bit          stubRespond = 0, stubSpurious = 0;
    int          stubLat = 1;
    logic [31:0] stubHi = '0, stubLo = '0;
    logic [31:0] expRs = '0, expRt = '0;

    bit          pendValid = 0, pendIsDiv = 0, spurValid = 0, spurIsDiv = 0;
    int          pendCycle = 0, spurCycle = 0;
    logic [31:0] pendHi = '0, pendLo = '0;
    int          divCount = 0, mulCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Result buses carry noise except in the cycle a stub completes.
    always @(posedge clock) begin
        #1;
        divOut = 1'b0;
        mulOut = 1'b0;
        divHi = $urandom; divLo = $urandom;
        mulHi = $urandom; mulLo = $urandom;
        if (pendValid && cyc == pendCycle) begin
            pendValid = 0;
            if (pendIsDiv) begin
                divOut = 1'b1; divHi = pendHi; divLo = pendLo;
            end else begin
                mulOut = 1'b1; mulHi = pendHi; mulLo = pendLo;
            end
        end
        if (spurValid && cyc == spurCycle) begin
            spurValid = 0;
            if (spurIsDiv) divOut = 1'b1;
            else           mulOut = 1'b1;
        end
    end

    // Strobe observer, stub scheduler and scoreboard monitor
    always @(negedge clock) begin
        if (divIn || mulIn) begin
            if (divIn) begin
                divCount++;
                checkOutput("divDividendo", divDividendo, expRs);
                checkOutput("divDivisor", divDivisor, expRt);
            end
            if (mulIn) begin
                mulCount++;
                checkOutput("mulA", mulA, expRs);
                checkOutput("mulB", mulB, expRt);
            end
            if (stubRespond) begin
                pendValid = 1; pendCycle = cyc + stubLat; pendIsDiv = divIn;
                pendHi = stubHi; pendLo = stubLo;
            end
            if (stubSpurious) begin
                spurValid = 1; spurCycle = cyc + 1; spurIsDiv = !divIn;
            end
        end
        if (done) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedDone: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                monE = expQ.pop_front();
                checkOutput("HiOut", HiOut, monE.hi);
                checkOutput("LoOut", LoOut, monE.lo);
                checkOutput("divZeroExc", {31'b0, divZeroExc}, {31'b0, monE.dz});
                checkOutput("timeoutErr", {31'b0, timeoutErr}, {31'b0, monE.to});
                checkOutput("busyInFinish", {31'b0, busy}, 32'd1);
                checkOutput("doneCycle", cyc, monE.doneCyc);
                checkOutput("divStrobes", divCount, monE.divStrobes);
                checkOutput("mulStrobes", mulCount, monE.mulStrobes);
            end
            divCount = 0;
            mulCount = 0;
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input bit respond, input int lat, input logic [31:0] rhi,
                                 input logic [31:0] rlo, input bit spurious, input bit poke,
                                 input bit expectDone);
        exp_t e;
        int   a;
        int   guard;
        bit   complete;
        guard = 0;
        @(negedge clock);
        while (busy && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL idleWait: got busy=1 expected busy=0 after %0d cycles", guard);
        end
        stubRespond = respond; stubLat = lat; stubHi = rhi; stubLo = rlo;
        stubSpurious = spurious; expRs = rs; expRt = rt;
        a = cyc + 1;
        opCode = op; rsData = rs; rtData = rt; opStart = 1'b1;

        complete = respond && lat >= 1 && lat <= TIMEOUT;
        e.dz = 0; e.to = 0; e.divStrobes = 0; e.mulStrobes = 0; e.doneCyc = a;
        case (op)
            2'b10: mHi = rs;
            2'b11: mLo = rs;
            default: begin
                if (op == 2'b01 && rt == 32'd0) begin
                    e.dz = 1;
                end else begin
                    if (op == 2'b01) e.divStrobes = 1;
                    else             e.mulStrobes = 1;
                    if (complete) begin
                        mHi = rhi; mLo = rlo;
                        e.doneCyc = a + lat + 1;
                    end else begin
                        e.to = 1;
                        e.doneCyc = a + TIMEOUT + 1;
                    end
                end
            end
        endcase
        e.hi = mHi;
        e.lo = mLo;
        if (expectDone) expQ.push_back(e);

        @(negedge clock);
        opStart = 1'b0;
        opCode = 2'($urandom); rsData = $urandom; rtData = $urandom;
        checkOutput("busyAfterAccept", {31'b0, busy}, 32'd1);
        if (poke) begin
            repeat (3) @(negedge clock);
            opStart = 1'b1; opCode = 2'b10; rsData = $urandom;
            @(negedge clock);
            opStart = 1'b0;
        end
        if (expectDone) begin
            guard = 0;
            while (!done && guard < 300) begin
                @(negedge clock);
                guard++;
            end
            if (!done) begin
                checks++;
                failures++;
                $display("[TB] FAIL doneWait: got done=0 expected done=1 within 300 cycles");
            end
            @(negedge clock);
            checkOutput("busyAfterDone", {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_HiOut"}, HiOut, 32'd0);
        checkOutput({tag, "_LoOut"}, LoOut, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
        checkOutput({tag, "_divZeroExc"}, {31'b0, divZeroExc}, 32'd0);
        checkOutput({tag, "_timeoutErr"}, {31'b0, timeoutErr}, 32'd0);
        checkOutput({tag, "_strobes"}, {30'b0, divIn, mulIn}, 32'd0);
        checkOutput({tag, "_divOperands"}, divDividendo | divDivisor, 32'd0);
        checkOutput({tag, "_mulOperands"}, mulA | mulB, 32'd0);
    endtask

    initial begin
        int          a;
        bit          launches, respond, poke;
        logic [1:0]  op;
        logic [31:0] rs, rt;
        int          lat;

        repeat (3) @(negedge clock);
        checkAllZero("inReset");
        reset = 1'b1;
        @(negedge clock);
        checkAllZero("afterReset");

        applyStimulus(2'b10, 32'h12345678, 32'd0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(2'b01, 32'd100, 32'd7, 1, 33, 32'd2, 32'd14, 0, 0, 1);
        applyStimulus(2'b01, 32'd55, 32'd0, 1, 5, 32'hDEAD, 32'hBEEF, 0, 0, 1);
        applyStimulus(2'b11, 32'd5, 32'd0, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(2'b00, 32'd3, 32'd4, 0, 1, 0, 0, 0, 0, 1);
        applyStimulus(2'b00, 32'd3, 32'd4, 1, 5, 32'd0, 32'd12, 0, 0, 1);
        applyStimulus(2'b01, 32'd1000, 32'd9, 1, 12, 32'd1, 32'd111, 1, 1, 1);
        applyStimulus(2'b00, 32'hAAAA, 32'h5555, 1, TIMEOUT, 32'h11, 32'h22, 0, 0, 1);
        applyStimulus(2'b01, 32'h77, 32'h3, 1, TIMEOUT + 1, 32'h33, 32'h44, 0, 0, 1);
        applyStimulus(2'b00, 32'h9, 32'h8, 1, 1, 32'h55, 32'h66, 1, 0, 1);

        for (int i = 0; i < 40; i++) begin
            op       = 2'($urandom_range(0, 3));
            rs       = $urandom;
            rt       = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            respond  = ($urandom_range(0, 7) != 0);
            lat      = $urandom_range(1, 36);
            launches = (op == 2'b00) || (op == 2'b01 && rt != 32'd0);
            poke     = launches && (!respond || lat >= 8) && ($urandom_range(0, 1) == 1);
            applyStimulus(op, rs, rt, respond, lat, $urandom, $urandom,
                          bit'($urandom_range(0, 1)), poke, 1);
        end

        // Abort a DIV mid-WAIT; its late divOut then lands in IDLE.
        applyStimulus(2'b01, 32'd1000, 32'd3, 1, 20, 32'h1, 32'h14D, 0, 0, 0);
        a = cyc;
        repeat (8) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        mHi = '0;
        mLo = '0;
        while (cyc < a + 24) @(negedge clock);
        checkAllZero("afterAbort");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
